// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline definitions for the unified memory port: data width,
// arbiter FSM encodings and the request/response bundles that the cache and
// MMIO blocks also use to talk to the single memory port.
package mem_port_arbiter_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_D = 2'd1,
      BUSY_I = 2'd2
   } arb_state_e;

   // Master side of the unified-memory handshake (held stable while req & ~ready).
   typedef struct packed {
      logic            req;
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } mem_req_t;

   // Slave side: ready completes the access in the current cycle.
   typedef struct packed {
      logic            ready;
      logic [XLEN-1:0] rdata;
   } mem_rsp_t;

   localparam mem_req_t MEM_REQ_IDLE = '{
      req:   1'b0,
      we:    1'b0,
      addr:  {XLEN{1'b0}},
      wdata: {XLEN{1'b0}}
   };

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one unified memory port between IF-stage fetch
// and MEM-stage load/store. Data has priority; a starvation counter forces a
// fetch through after FETCH_STARVE_MAX consecutive data grants.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned FETCH_STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_kill,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_ready,
   input  logic [31:0] m_rdata
);

   localparam int unsigned      CNT_W      = $clog2(FETCH_STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(FETCH_STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);

   arb_state_e       state_q, state_d;
   mem_req_t         mreq_q, mreq_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             kill_q, kill_d;
   logic [31:0]      if_rdata_q, if_rdata_d;
   logic [31:0]      d_rdata_q, d_rdata_d;
   logic             if_valid_q, if_valid_d;
   logic             d_valid_q, d_valid_d;

   logic fetch_live_s;
   logic starve_hit_s;
   logic pulse_out_s;
   logic grant_d_s;
   logic grant_i_s;

   // A fetch being flushed this cycle is not a candidate for the port.
   assign fetch_live_s = if_req & ~if_kill;
   assign starve_hit_s = (starve_cnt_q == STARVE_MAX) & fetch_live_s;
   // While a completion pulse is out, the requester's req still refers to the
   // access just finished, so that cycle is a turnaround with no grant.
   assign pulse_out_s  = if_valid_q | d_valid_q;

   // Grant selection in IDLE: data first unless fetch has hit the starve limit.
   always_comb begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
      if ((state_q == IDLE) && !pulse_out_s) begin
         if (d_req && !starve_hit_s) begin
            grant_d_s = 1'b1;
         end else if (fetch_live_s) begin
            grant_i_s = 1'b1;
         end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
         end
      end else begin
         grant_d_s = 1'b0;
         grant_i_s = 1'b0;
      end
   end

   // Next-state, memory-request, starvation and completion logic.
   always_comb begin
      state_d      = state_q;
      mreq_d       = mreq_q;
      starve_cnt_d = starve_cnt_q;
      kill_d       = kill_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_valid_d   = 1'b0;
      d_valid_d    = 1'b0;
      case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (grant_d_s) begin
               mreq_d  = '{req: 1'b1, we: d_we, addr: d_addr, wdata: d_wdata};
               state_d = BUSY_D;
            end else if (grant_i_s) begin
               mreq_d  = '{req: 1'b1, we: 1'b0, addr: if_addr, wdata: 32'h0000_0000};
               state_d = BUSY_I;
            end else begin
               state_d = IDLE;
            end
            if (!if_req || grant_i_s) begin
               starve_cnt_d = CNT_ZERO;
            end else if (grant_d_s && (starve_cnt_q != STARVE_MAX)) begin
               starve_cnt_d = starve_cnt_q + CNT_ONE;
            end else begin
               starve_cnt_d = starve_cnt_q;
            end
         end
         BUSY_D: begin
            if (m_ready) begin
               mreq_d.req = 1'b0;
               state_d    = IDLE;
               d_valid_d  = 1'b1;
               if (!mreq_q.we) begin
                  d_rdata_d = m_rdata;
               end else begin
                  d_rdata_d = d_rdata_q;
               end
            end else begin
               state_d = BUSY_D;
            end
         end
         BUSY_I: begin
            if (m_ready) begin
               mreq_d.req = 1'b0;
               state_d    = IDLE;
               kill_d     = 1'b0;
               if (kill_q || if_kill) begin
                  if_valid_d = 1'b0;
               end else begin
                  if_valid_d = 1'b1;
                  if_rdata_d = m_rdata;
               end
            end else begin
               state_d = BUSY_I;
               kill_d  = kill_q | if_kill;
            end
         end
         default: begin
            state_d      = IDLE;
            mreq_d       = MEM_REQ_IDLE;
            starve_cnt_d = CNT_ZERO;
            kill_d       = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         mreq_q       <= MEM_REQ_IDLE;
         starve_cnt_q <= CNT_ZERO;
         kill_q       <= 1'b0;
         if_rdata_q   <= 32'h0000_0000;
         d_rdata_q    <= 32'h0000_0000;
         if_valid_q   <= 1'b0;
         d_valid_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mreq_q       <= mreq_d;
         starve_cnt_q <= starve_cnt_d;
         kill_q       <= kill_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_valid_q   <= if_valid_d;
         d_valid_q    <= d_valid_d;
      end
   end

   assign m_req     = mreq_q.req;
   assign m_we      = mreq_q.we;
   assign m_addr    = mreq_q.addr;
   assign m_wdata   = mreq_q.wdata;
   assign if_rdata  = if_rdata_q;
   assign if_valid  = if_valid_q;
   assign d_rdata   = d_rdata_q;
   assign d_valid   = d_valid_q;
   assign stall_if  = if_req & ~if_valid_q;
   assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// grant addresses and read data into queues; a monitor pops on each grant
// and valid pulse. A small memory model supplies ready after wait_cfg waits.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_kill, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
   logic        if_valid, d_valid, stall_if, stall_mem, m_req, m_we, m_ready;

   int wait_cfg;
   int wcnt;
   int n_vec;
   int n_fail;
   logic m_req_prev;

   logic [31:0] exp_grant[$];
   logic [31:0] exp_d[$];
   logic [31:0] exp_i[$];

   mem_port_arbiter #(.FETCH_STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'hDEAD_BEEF;
         32'h0000_0040: return 32'h00C0_FFEE;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign m_rdata = mem_model(m_addr);
   assign m_ready = m_req && (wcnt >= wait_cfg);

   // Count wait cycles of the current memory access.
   always @(posedge clk) begin
      wcnt <= (m_req && !m_ready) ? wcnt + 1 : 0;
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check32(name, {31'd0, act}, {31'd0, exp});
   endtask

   // Monitor: compare every grant and every completion against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_req && !m_req_prev) begin
            if (exp_grant.size() == 0) check1("unexpected_grant", m_req, 1'b0);
            else check32("grant_addr", m_addr, exp_grant.pop_front());
         end
         if (d_valid) begin
            if (exp_d.size() == 0) check1("unexpected_d_valid", d_valid, 1'b0);
            else check32("d_rdata", d_rdata, exp_d.pop_front());
         end
         if (if_valid) begin
            if (exp_i.size() == 0) check1("unexpected_if_valid", if_valid, 1'b0);
            else check32("if_rdata", if_rdata, exp_i.pop_front());
         end
      end
      m_req_prev <= m_req;
   end

   task automatic wait_valid(input bit want_d, input int budget, input string name);
      bit got;
      got = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (want_d ? d_valid : if_valid) begin
            got = 1'b1;
            break;
         end
      end
      check1(name, got, 1'b1);
   endtask

   initial begin
      int nd;
      int ni;
      bit fchk;
      n_vec = 0; n_fail = 0; wcnt = 0; wait_cfg = 0; m_req_prev = 1'b0;
      rst = 1'b1; if_req = 1'b0; if_kill = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check1("rst_m_req", m_req, 1'b0);
      check1("rst_m_we", m_we, 1'b0);
      check32("rst_m_addr", m_addr, 32'h0);
      check32("rst_m_wdata", m_wdata, 32'h0);
      check1("rst_d_valid", d_valid, 1'b0);
      check1("rst_if_valid", if_valid, 1'b0);
      check32("rst_d_rdata", d_rdata, 32'h0);
      check32("rst_if_rdata", if_rdata, 32'h0);
      rst = 1'b0;

      // Zero-wait load
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; wait_cfg = 0;
      exp_grant.push_back(32'h100); exp_d.push_back(32'hDEAD_BEEF);
      #1 check1("load_stall_c0", stall_mem, 1'b1);
      @(negedge clk);
      check1("load_m_req_c1", m_req, 1'b1);
      check1("load_m_we_c1", m_we, 1'b0);
      check1("load_stall_c1", stall_mem, 1'b1);
      check1("load_d_valid_c1", d_valid, 1'b0);
      @(negedge clk);
      check1("load_d_valid_c2", d_valid, 1'b1);
      check1("load_stall_c2", stall_mem, 1'b0);
      d_req = 1'b0;
      @(negedge clk);
      check1("load_d_valid_c3", d_valid, 1'b0);
      check1("load_m_req_c3", m_req, 1'b0);

      // Store with 3 wait states
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; wait_cfg = 3;
      exp_grant.push_back(32'h200); exp_d.push_back(32'hDEAD_BEEF);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check1("store_m_req", m_req, 1'b1);
         check1("store_m_we", m_we, 1'b1);
         check32("store_m_addr", m_addr, 32'h200);
         check32("store_m_wdata", m_wdata, 32'h1234_5678);
         check1("store_no_valid", d_valid, 1'b0);
      end
      @(negedge clk);
      check1("store_d_valid_c5", d_valid, 1'b1);
      check32("store_d_rdata_held", d_rdata, 32'hDEAD_BEEF);
      d_req = 1'b0; d_we = 1'b0;

      // Fetch kill while waiting, then refetch at 0x40
      @(negedge clk);
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0; wait_cfg = 100;
      exp_grant.push_back(32'h0);
      @(negedge clk);
      check1("kill_m_req_c1", m_req, 1'b1);
      check1("kill_stall_if_c1", stall_if, 1'b1);
      @(negedge clk);
      if_kill = 1'b1; if_addr = 32'h40;
      exp_grant.push_back(32'h40); exp_i.push_back(32'h00C0_FFEE);
      @(negedge clk);
      if_kill = 1'b0; wait_cfg = 2;
      check32("kill_m_addr_held", m_addr, 32'h0);
      @(negedge clk);
      check1("kill_no_if_valid", if_valid, 1'b0);
      check1("kill_m_req_dropped", m_req, 1'b0);
      wait_cfg = 0;
      wait_valid(1'b0, 10, "refetch_timeout");
      if_req = 1'b0;

      // Contention: both requests held high, limit 4
      @(negedge clk);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; if_req = 1'b1; if_addr = 32'h1000;
      wait_cfg = 0;
      exp_grant.push_back(32'h2000); exp_grant.push_back(32'h2004);
      exp_grant.push_back(32'h2008); exp_grant.push_back(32'h200C);
      exp_grant.push_back(32'h1000); exp_grant.push_back(32'h2010);
      exp_d.push_back(32'h5A5A_2000); exp_d.push_back(32'h5A5A_2004);
      exp_d.push_back(32'h5A5A_2008); exp_d.push_back(32'h5A5A_200C);
      exp_d.push_back(32'h5A5A_2010);
      exp_i.push_back(32'h5A5A_1000);
      nd = 0; ni = 0; fchk = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (m_req && (m_addr == 32'h1000) && !fchk) begin
            fchk = 1'b1;
            check32("starve_cleared", 32'(dut.starve_cnt_q), 32'd0);
         end
         if (d_valid) begin
            nd++;
            if (nd == 4) check32("starve_saturated", 32'(dut.starve_cnt_q), 32'd4);
            d_addr = d_addr + 32'd4;
         end
         if (if_valid) begin
            ni++;
            if_addr = if_addr + 32'd4;
         end
         if (nd + ni == 6) break;
      end
      check32("contention_done", 32'(nd + ni), 32'd6);
      check1("contention_fetch_seen", fchk, 1'b1);
      d_req = 1'b0; if_req = 1'b0;

      // Reset in the middle of a data access
      @(negedge clk);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; wait_cfg = 100;
      exp_grant.push_back(32'h300);
      @(negedge clk);
      check1("mid_m_req_c1", m_req, 1'b1);
      @(negedge clk);
      rst = 1'b1; d_req = 1'b0;
      @(negedge clk);
      check1("mid_m_req", m_req, 1'b0);
      check1("mid_m_we", m_we, 1'b0);
      check32("mid_m_addr", m_addr, 32'h0);
      check32("mid_m_wdata", m_wdata, 32'h0);
      check1("mid_d_valid", d_valid, 1'b0);
      check32("mid_d_rdata", d_rdata, 32'h0);
      check32("mid_if_rdata", if_rdata, 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check1("mid_idle_m_req", m_req, 1'b0);

      // Post-reset load proves the FSM is back in IDLE
      d_req = 1'b1; d_addr = 32'h100; wait_cfg = 0;
      exp_grant.push_back(32'h100); exp_d.push_back(32'hDEAD_BEEF);
      wait_valid(1'b1, 10, "post_reset_timeout");
      d_req = 1'b0;

      repeat (3) @(negedge clk);
      check32("grant_queue_empty", exp_grant.size(), 32'd0);
      check32("d_queue_empty", exp_d.size(), 32'd0);
      check32("i_queue_empty", exp_i.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and sequencer for the 5-stage pipeline. Shares one unified instruction/data memory port between the IF-stage fetch and the MEM-stage load/store carried by the EX/MEM register. It runs a request/ready handshake to memory and raises stall signals until each access completes. Data access has priority, and a starvation counter bounds how long fetch can be locked out.

## Interface
- FETCH_STARVE_MAX, 4, max consecutive data grants while fetch is pending before fetch is forced through (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  32  fetch address (PC)
- if_kill  in  1  branch/jump flush: drop the pending or in-flight fetch result
- if_rdata  out  32  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  EX_MEM_MemRead | EX_MEM_MemWrite, held until d_valid
- d_we  in  1  EX_MEM_MemWrite
- d_addr  in  32  EX_MEM_ALUout
- d_wdata  in  32  EX_MEM_RD2
- d_rdata  out  32  load data, valid with d_valid
- d_valid  out  1  one-cycle data completion pulse (loads and stores)
- stall_if  out  1  if_req & ~if_valid
- stall_mem  out  1  d_req & ~d_valid
- m_req, m_we  out  1  memory request / write enable (registered)
- m_addr, m_wdata  out  32  memory address / write data (registered)
- m_ready  in  1  memory completes the access in the current cycle
- m_rdata  in  32  memory read data, sampled when m_req & m_ready

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I.
- IDLE, grant rule:
  - Grant data if d_req and not (starve_cnt == FETCH_STARVE_MAX and if_req & ~if_kill).
  - Otherwise grant fetch if if_req & ~if_kill.
  - Otherwise stay in IDLE.
- On grant: latch addr, we (0 for fetch), wdata into m_* registers; set m_req=1; go to BUSY_D or BUSY_I.
- BUSY_x:
  - Hold m_* stable while m_req & ~m_ready.
  - On m_ready: drop m_req next edge and return to IDLE.
  - Also on m_ready: capture m_rdata into d_rdata or if_rdata and pulse the matching valid next cycle.
- Stores: d_valid pulses; d_rdata holds its previous value.
- starve_cnt:
  - Increments on each data grant while if_req is pending, saturating at FETCH_STARVE_MAX.
  - Clears on a fetch grant, or when if_req is low in IDLE.
- if_kill:
  - In IDLE, the pending fetch is not granted.
  - In BUSY_I, the memory transaction runs to completion (the handshake is never aborted) and if_valid is suppressed for it.
  - The sticky kill flag clears on return to IDLE.
- stall_if and stall_mem are combinational from current inputs and the registered valids. The hazard unit ORs them into the pipeline freeze.

## Timing
- Reset (rst=1 at edge):
  - State IDLE; starve_cnt=0; kill flag=0.
  - m_req, m_we, if_valid, d_valid = 0.
  - m_addr, m_wdata, if_rdata, d_rdata = 0.
- Reset mid-transaction: m_req deasserts at that edge and no valid pulse is produced.
- Zero-wait memory latency:
  - Request seen in IDLE at edge N gives m_req=1 in cycle N+1.
  - m_ready=1 in that cycle gives valid=1 in cycle N+2.
  - Back-to-back accesses: one access per 3 cycles (IDLE turnaround).
- Each wait cycle (m_ready=0 while m_req=1) adds one cycle of latency.
- Simultaneous d_req and if_req in IDLE: data wins unless the starve limit is reached.
- The valid pulse lasts exactly one cycle. A requester that keeps its req high after valid is treated as a new request.

## Structure
- Shared pipeline package/header holds:
  - FSM state encodings (IDLE=2'd0, BUSY_D=2'd1, BUSY_I=2'd2);
  - XLEN=32;
  - the unified-memory handshake signal definitions, reused by the cache/MMIO blocks.
- Flat single module; grant selection is a small always block, with no sub-module.

## Test plan
- Zero-wait load: d_req=1, d_we=0, d_addr=0x100, m_rdata=0xDEADBEEF, m_ready always 1 -> m_req in cycle 1, d_valid and d_rdata=0xDEADBEEF in cycle 2, stall_mem=1 in cycles 0–1.
- Store with 3 wait states: d_we=1, d_addr=0x200, d_wdata=0x12345678 -> m_addr and m_wdata held 4 cycles, d_valid in cycle 5, d_rdata unchanged.
- Contention: if_req and d_req both high continuously with FETCH_STARVE_MAX=4 -> grant order D,D,D,D,I,D…; starve_cnt returns to 0 after the fetch grant.
- Fetch kill: fetch 0x0 granted, if_kill pulsed while m_ready=0 -> transaction completes, no if_valid; next fetch at 0x40 returns correct data.
- Reset mid-access: rst asserted during BUSY_D with m_ready=0 -> next cycle m_req=0, state IDLE, no d_valid, all outputs 0.
